sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
- Message-block buffer and message-schedule generator; sits directly downstream of the Avalon interface stage.
- Consumes its registered cycle strobes, word address and write data.
- Stores one 512-bit block as 16 x 32-bit words, exposes a command/status register pair, and streams W[0..63] to the compression round engine over a valid/ready handshake.
- Drives SLAVE_READY back to the interface stage.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block.
- BCNT_W, 16, width of the completed-block counter in the status register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- ram_wr_cycle  in  1  message-buffer write access active (level, held several cycles)
- ram_read_cycle  in  1  message-buffer read access active (level)
- command_wr_cycle  in  1  command-register write access active (level)
- status_rd_cycle  in  1  status-register read access active (level)
- ava_reg_wr_data  in  32  registered bus write data
- ava_reg_address  in  12  registered word address; [3:0] selects buffer word
- avalon_rd_reg  out  32  buffer read data
- status_rd_reg  out  32  status register
- slave_ready  out  1  access may complete
- w_data  out  32  schedule word W[t]
- w_round  out  6  t of current w_data
- w_valid  out  1  w_data valid
- w_ready  in  1  round engine accepts w_data
- block_done  out  1  one-cycle pulse after W[63] is accepted

Behaviour:
- Reset (async, reset_n low): state IDLE; window[0..15]=0; round counter=0; block counter=0; done=0.
- Reset outputs: avalon_rd_reg=0, slave_ready=1, w_valid=0, block_done=0.
- Reset mid-run: aborts the block immediately; no block_done pulse.
- Strobe edges: each cycle input is registered; an action fires only on the first cycle the input is high (rising edge). Holding a strobe high never repeats the action.
- Buffer write (ram_wr_cycle edge, state IDLE or DONE): window[addr[3:0]] <= ava_reg_wr_data. Applied the cycle after the edge.
- Buffer read: avalon_rd_reg <= window[addr[3:0]] every cycle while ram_read_cycle is high. Registered, 1-cycle latency.
- Read after a run returns the scheduled window contents, not the loaded words. This is defined behaviour.
- Command write (command_wr_cycle edge); ava_reg_wr_data bits:
  - bit0: start; IDLE/DONE -> RUN; round=0; done cleared.
  - bit1: clear done flag.
  - bit2: abort; any state -> IDLE; round=0; window retained.
  - If abort and start are set in the same write, abort wins.
  - Start while in RUN is ignored.
- Status register: [0] busy (state==RUN); [1] done (sticky); [13:8] round counter; [31:16] block counter (wraps at 2^BCNT_W-1 -> 0). Other bits read 0. Combinational from registers.
- slave_ready: 0 while ram_wr_cycle=1 and state==RUN, which stalls the bus write until the block completes. Otherwise 1. Reads and command writes are never stalled.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when a transfer occurs with round==63.
  - DONE -> RUN on start.
  - Any state -> IDLE on abort.
  - DONE and IDLE both accept buffer writes.
- RUN datapath:
  - w_valid=1; w_data=window[0]; w_round=round.
  - Transfer = w_valid & w_ready.
  - On each transfer: window shifts down one place (window[i] <= window[i+1]); round increments.
  - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - The new word is computed on every transfer, including rounds 48..63, where it is unused.
- w_ready low: holds w_data, w_round and window stable; no timeout.
- Completion: on the round-63 transfer, block_done pulses 1 cycle, done is set, block counter increments, w_valid drops the next cycle, and round returns to 0.

Test Plan:
- Reset: all outputs at reset values; status_rd_reg=0x00000000; slave_ready=1.
- "abc" block: load W0=0x61626380, W1..W14=0, W15=0x00000018, then start with w_ready=1 -> W0..W15 echo the loaded words; W16=0x61626380; W17=0x000F0000; block_done after 64 transfers; status=0x00010002.
- Backpressure: toggle w_ready pseudo-randomly on the "abc" block -> identical W sequence; w_data/w_round held while stalled; exactly 64 transfers.
- Write during RUN: bus write to word 3 mid-run -> slave_ready=0 until the cycle after block_done; write then lands in window[3]; schedule output unaffected.
- Strobe hold and abort: command_wr_cycle held 4 cycles with data 0x1 -> single start. Abort (0x5) at round 20 -> busy=0, round=0, no block_done, block counter unchanged.
- Counter wrap: preload block counter to 0xFFFF via 65535 runs (or force), run one more -> status[31:16]=0x0000.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-block buffer and schedule generator.
// Holds a 16-word sliding window and streams W[0..ROUNDS-1] to the round engine.
module sha256_msg_sched #(
   parameter int unsigned ROUNDS = 64,
   parameter int unsigned BCNT_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ram_wr_cycle,
   input  logic        ram_read_cycle,
   input  logic        command_wr_cycle,
   input  logic        status_rd_cycle,
   input  logic [31:0] ava_reg_wr_data,
   input  logic [11:0] ava_reg_address,
   output logic [31:0] avalon_rd_reg,
   output logic [31:0] status_rd_reg,
   output logic        slave_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_round,
   output logic        w_valid,
   input  logic        w_ready,
   output logic        block_done
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned RND_W  = 6;
   localparam int unsigned NWORDS = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [WORD_W-1:0]   window [NWORDS];
   logic [RND_W-1:0]    round;
   logic [BCNT_W-1:0]   bcnt;
   logic                done;
   logic                ram_wr_q;
   logic                cmd_wr_q;
   logic                wr_pend;

   logic                wr_edge;
   logic                cmd_edge;
   logic                cmd_abort;
   logic                cmd_start;
   logic                cmd_clear;
   logic                xfer;
   logic                shift;
   logic                last;
   logic                wr_apply;
   logic [WORD_W-1:0]   new_word;
   logic                unused_inputs;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Strobe edge detection and command decode; abort dominates start.
   assign wr_edge   = ram_wr_cycle & ~ram_wr_q;
   assign cmd_edge  = command_wr_cycle & ~cmd_wr_q;
   assign cmd_abort = cmd_edge & ava_reg_wr_data[2];
   assign cmd_start = cmd_edge & ava_reg_wr_data[0] & ~ava_reg_wr_data[2] & (state != RUN);
   assign cmd_clear = cmd_edge & ava_reg_wr_data[1];
   assign xfer      = (state == RUN) & w_valid & w_ready;
   assign shift     = xfer & ~cmd_abort;
   assign last      = shift & (round == RND_W'(ROUNDS - 1));
   // A write seen during RUN is parked and lands once the block has finished.
   assign wr_apply  = (wr_edge | wr_pend) & (state != RUN);

   assign new_word  = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

   assign w_data        = window[0];
   assign w_round       = round;
   assign status_rd_reg = {16'(bcnt), 2'b00, round, 6'b000000, done, state == RUN};
   assign unused_inputs = ^{status_rd_cycle, ava_reg_address[11:4], ava_reg_wr_data[31:3]};

   // Control state, counters and registered bus outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         round         <= '0;
         bcnt          <= '0;
         done          <= 1'b0;
         ram_wr_q      <= 1'b0;
         cmd_wr_q      <= 1'b0;
         wr_pend       <= 1'b0;
         avalon_rd_reg <= '0;
         slave_ready   <= 1'b1;
         w_valid       <= 1'b0;
         block_done    <= 1'b0;
      end else begin
         ram_wr_q    <= ram_wr_cycle;
         cmd_wr_q    <= command_wr_cycle;
         block_done  <= 1'b0;
         slave_ready <= ~(ram_wr_cycle & (state == RUN));

         if (wr_apply)
            wr_pend <= 1'b0;
         else if (wr_edge)
            wr_pend <= 1'b1;

         if (ram_read_cycle)
            avalon_rd_reg <= window[ava_reg_address[3:0]];

         if (cmd_abort) begin
            state   <= IDLE;
            round   <= '0;
            w_valid <= 1'b0;
         end else if (cmd_start) begin
            state   <= RUN;
            round   <= '0;
            w_valid <= 1'b1;
            done    <= 1'b0;
         end else if (last) begin
            state      <= DONE;
            round      <= '0;
            w_valid    <= 1'b0;
            done       <= 1'b1;
            bcnt       <= bcnt + BCNT_W'(1);
            block_done <= 1'b1;
         end else if (shift) begin
            round <= round + RND_W'(1);
         end

         if (cmd_clear)
            done <= 1'b0;
      end
   end

   // Message window: load port when idle, shift register with schedule recurrence when running.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NWORDS; i++)
            window[i] <= '0;
      end else if (shift) begin
         for (int i = 0; i < NWORDS - 1; i++)
            window[i] <= window[i + 1];
         window[NWORDS - 1] <= new_word;
      end else if (wr_apply) begin
         window[ava_reg_address[3:0]] <= ava_reg_wr_data;
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: randomized backpressure against a SHA-256 schedule model.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ram_wr_cycle = 1'b0;
   logic        ram_read_cycle = 1'b0;
   logic        command_wr_cycle = 1'b0;
   logic        status_rd_cycle = 1'b0;
   logic [31:0] ava_reg_wr_data = '0;
   logic [11:0] ava_reg_address = '0;
   logic        w_ready = 1'b0;
   logic [31:0] avalon_rd_reg, status_rd_reg, w_data;
   logic [5:0]  w_round;
   logic        slave_ready, w_valid, block_done;
   logic [31:0] unused_w2_rd, w2_status, unused_w2_data;
   logic [5:0]  unused_w2_round;
   logic        unused_w2_srdy, unused_w2_valid, unused_w2_done;

   int checks = 0;
   int errors = 0;
   int nblocks = 0;
   logic [31:0] ld [16];
   logic [31:0] ew [80];

   sha256_msg_sched dut (
      .clk(clk), .reset_n(reset_n), .ram_wr_cycle(ram_wr_cycle), .ram_read_cycle(ram_read_cycle),
      .command_wr_cycle(command_wr_cycle), .status_rd_cycle(status_rd_cycle),
      .ava_reg_wr_data(ava_reg_wr_data), .ava_reg_address(ava_reg_address),
      .avalon_rd_reg(avalon_rd_reg), .status_rd_reg(status_rd_reg), .slave_ready(slave_ready),
      .w_data(w_data), .w_round(w_round), .w_valid(w_valid), .w_ready(w_ready), .block_done(block_done));

   // Narrow block counter instance so the wrap can be reached in a few blocks.
   sha256_msg_sched #(.BCNT_W(2)) dut_w (
      .clk(clk), .reset_n(reset_n), .ram_wr_cycle(ram_wr_cycle), .ram_read_cycle(ram_read_cycle),
      .command_wr_cycle(command_wr_cycle), .status_rd_cycle(status_rd_cycle),
      .ava_reg_wr_data(ava_reg_wr_data), .ava_reg_address(ava_reg_address),
      .avalon_rd_reg(unused_w2_rd), .status_rd_reg(w2_status), .slave_ready(unused_w2_srdy),
      .w_data(unused_w2_data), .w_round(unused_w2_round), .w_valid(unused_w2_valid),
      .w_ready(w_ready), .block_done(unused_w2_done));

   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 expansion, extended past 63 to predict the final window.
   function automatic void build_model();
      for (int t = 0; t < 16; t++) ew[t] = ld[t];
      for (int t = 16; t < 80; t++)
         ew[t] = (rr(ew[t-2], 17) ^ rr(ew[t-2], 19) ^ (ew[t-2] >> 10)) + ew[t-7]
               + (rr(ew[t-15], 7) ^ rr(ew[t-15], 18) ^ (ew[t-15] >> 3)) + ew[t-16];
   endfunction

   function automatic logic [31:0] exp_status(input bit done, input bit busy, input int rnd);
      logic [15:0] b = 16'(nblocks);
      logic [5:0]  r = 6'(rnd);
      return {b, 2'b00, r, 6'b000000, done, busy};
   endfunction

   task automatic write_word(input int a, input logic [31:0] d);
      @(negedge clk);
      ram_wr_cycle = 1'b1; ava_reg_address = 12'(a); ava_reg_wr_data = d;
      @(negedge clk);
      ram_wr_cycle = 1'b0;
   endtask

   task automatic cmd(input logic [31:0] d, input int hold);
      @(negedge clk);
      command_wr_cycle = 1'b1; ava_reg_wr_data = d;
      repeat (hold) @(negedge clk);
      command_wr_cycle = 1'b0;
   endtask

   task automatic load_block();
      for (int i = 0; i < 16; i++) write_word(i, ld[i]);
      build_model();
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) ld[i] = 32'h0;
      ld[0] = 32'h61626380; ld[15] = 32'h00000018;
      load_block();
   endtask

   task automatic load_random();
      for (int i = 0; i < 16; i++) ld[i] = $urandom;
      load_block();
   endtask

   task automatic read_word(input string nm, input int a, input logic [31:0] exp);
      @(negedge clk);
      ram_read_cycle = 1'b1; ava_reg_address = 12'(a);
      @(negedge clk);
      ram_read_cycle = 1'b0;
      checks++;
      if (avalon_rd_reg !== exp) begin
         errors++; $display("FAIL %s word%0d got %h exp %h", nm, a, avalon_rd_reg, exp);
      end
   endtask

   // Drives w_ready, checks every transfer against the model; optional mid-run write or abort.
   task automatic run_block(input string nm, input int pct, input bit inj, input logic [31:0] inj_val,
                            input int abort_at);
      int idx = 0, dones = 0, cyc = 0, wr_age = 0;
      bit stalled = 0, wr_on = 0, injected = 0, fin = 0;
      logic [31:0] hd = '0;
      logic [5:0]  hr = '0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (cyc > 4000) begin
            checks++; errors++; $display("FAIL %s timeout idx=%0d exp 64", nm, idx);
            w_ready = 1'b0; ram_wr_cycle = 1'b0;
            break;
         end
         if (block_done) begin
            dones++; checks++;
            if (idx !== 64 || w_valid !== 1'b0 || dones != 1) begin
               errors++;
               $display("FAIL %s block_done idx=%0d valid=%b pulses=%0d exp 64/0/1", nm, idx, w_valid, dones);
            end
         end
         if (stalled && w_valid) begin
            checks++;
            if (w_data !== hd || w_round !== hr) begin
               errors++; $display("FAIL %s hold got %h/%0d exp %h/%0d", nm, w_data, w_round, hd, hr);
            end
         end
         if (wr_on) begin
            wr_age++;
            if (dones == 0 || block_done) begin
               if (wr_age > 1) begin
                  checks++;
                  if (slave_ready !== 1'b0) begin
                     errors++; $display("FAIL %s slave_ready stall got %b exp 0", nm, slave_ready);
                  end
               end
            end else begin
               checks++;
               if (slave_ready !== 1'b1) begin
                  errors++; $display("FAIL %s slave_ready release got %b exp 1", nm, slave_ready);
               end
               ram_wr_cycle = 1'b0; wr_on = 0;
            end
         end
         if (inj && !injected && idx == 10) begin
            ram_wr_cycle = 1'b1; ava_reg_address = 12'd3; ava_reg_wr_data = inj_val;
            injected = 1; wr_on = 1;
         end
         if (abort_at >= 0 && w_valid && w_round == 6'(abort_at)) begin
            w_ready = 1'b0; command_wr_cycle = 1'b1; ava_reg_wr_data = 32'h5;
            fin = 1;
         end else if (dones > 0 && !wr_on) begin
            w_ready = 1'b0; fin = 1;
         end else begin
            w_ready = ($urandom_range(99) < pct);
            stalled = 0;
            if (w_valid && w_ready) begin
               checks++;
               if (idx >= 64) begin
                  errors++; $display("FAIL %s extra transfer got %0d exp 64", nm, idx);
               end else if (w_data !== ew[idx] || w_round !== 6'(idx)) begin
                  errors++;
                  $display("FAIL %s W[%0d] got %h/%0d exp %h/%0d", nm, idx, w_data, w_round, ew[idx], idx);
               end
               idx++;
            end else if (w_valid) begin
               stalled = 1; hd = w_data; hr = w_round;
            end
         end
      end
      if (abort_at < 0) begin
         nblocks++;
         repeat (2) begin
            @(negedge clk);
            checks++;
            if (block_done !== 1'b0 || w_valid !== 1'b0) begin
               errors++; $display("FAIL %s after done got %b/%b exp 0/0", nm, block_done, w_valid);
            end
         end
      end
   endtask

   task automatic check_status(input string nm, input logic [31:0] exp);
      checks++;
      if (status_rd_reg !== exp) begin
         errors++; $display("FAIL %s status got %h exp %h", nm, status_rd_reg, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (avalon_rd_reg !== 32'h0 || status_rd_reg !== 32'h0 || slave_ready !== 1'b1 ||
          w_valid !== 1'b0 || block_done !== 1'b0) begin
         errors++;
         $display("FAIL reset got rd=%h st=%h rdy=%b v=%b bd=%b exp 0/0/1/0/0",
                  avalon_rd_reg, status_rd_reg, slave_ready, w_valid, block_done);
      end
      reset_n = 1'b1;
      read_word("reset_window", 7, 32'h0);
   endtask

   task automatic test_abc();
      load_abc();
      checks++;
      if (ew[16] !== 32'h61626380 || ew[17] !== 32'h000F0000) begin
         errors++; $display("FAIL abc_model W16/W17 got %h/%h exp 61626380/000f0000", ew[16], ew[17]);
      end
      cmd(32'h1, 1);
      run_block("abc", 100, 0, 32'h0, -1);
      check_status("abc", 32'h00010002);
      read_word("abc_final", 0, ew[64]);
   endtask

   task automatic test_backpressure();
      load_abc();
      cmd(32'h1, 1);
      run_block("backpressure", 45, 0, 32'h0, -1);
      check_status("backpressure", exp_status(1, 0, 0));
   endtask

   task automatic test_write_during_run();
      logic [31:0] v = $urandom;
      load_random();
      cmd(32'h1, 1);
      run_block("wr_run", 100, 1, v, -1);
      read_word("wr_run_landed", 3, v);
      read_word("wr_run_other", 4, ew[68]);
   endtask

   task automatic test_strobe_abort();
      int base = nblocks;
      load_random();
      cmd(32'h1, 4);
      run_block("abort", 100, 0, 32'h0, 20);
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (w_valid !== 1'b0 || block_done !== 1'b0 || status_rd_reg !== exp_status(0, 0, 0)) begin
            errors++;
            $display("FAIL abort got v=%b bd=%b st=%h exp 0/0/%h", w_valid, block_done, status_rd_reg,
                     exp_status(0, 0, 0));
         end
      end
      command_wr_cycle = 1'b0;
      checks++;
      if (nblocks != base) begin
         errors++; $display("FAIL abort_count got %0d exp %0d", nblocks, base);
      end
      read_word("abort_retain0", 0, ew[20]);
      read_word("abort_retain15", 15, ew[35]);
      for (int i = 0; i < 16; i++) ld[i] = ew[20 + i];
      build_model();
      cmd(32'h1, 1);
      run_block("back_to_back", 70, 0, 32'h0, -1);
      check_status("back_to_back", exp_status(1, 0, 0));
      cmd(32'h2, 3);
      @(negedge clk);
      check_status("clear_done", exp_status(0, 0, 0));
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         load_random();
         cmd(32'h1, 1);
         run_block("random", 30 + 40 * k, 0, 32'h0, -1);
      end
   endtask

   task automatic test_wrap();
      bit wrapped = 0;
      while (!wrapped) begin
         load_random();
         cmd(32'h1, 1);
         run_block("wrap", 100, 0, 32'h0, -1);
         checks++;
         if (w2_status[31:16] !== 16'(nblocks % 4) || status_rd_reg[31:16] !== 16'(nblocks)) begin
            errors++;
            $display("FAIL wrap count got %h/%h exp %h/%h", w2_status[31:16], status_rd_reg[31:16],
                     16'(nblocks % 4), 16'(nblocks));
         end
         wrapped = (nblocks % 4 == 0);
      end
   endtask

   task automatic test_reset_midrun();
      load_random();
      cmd(32'h1, 1);
      w_ready = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b0; w_ready = 1'b0; nblocks = 0;
      @(negedge clk);
      checks++;
      if (w_valid !== 1'b0 || block_done !== 1'b0 || status_rd_reg !== 32'h0 || slave_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midrun got v=%b bd=%b st=%h rdy=%b exp 0/0/0/1", w_valid, block_done,
                  status_rd_reg, slave_ready);
      end
      reset_n = 1'b1;
      read_word("reset_midrun_window", 5, 32'h0);
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_write_during_run();
      test_strobe_abort();
      test_random();
      test_wrap();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
